// File: rtl/gam_memory_layer_seq.sv
// GAM memory-layer sequencer: scans stored nodes for the two nearest (s1/s2),
// then either reports the winner (recall) or issues the learning writes
// (new node, or update s1/s2 plus connect). Owns node_count and overflow.
module gam_memory_layer_seq #(
  parameter int NODE_AW   = 6,
  parameter int MAX_NODES = 64,
  parameter int DIST_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 learn_en,
  input  logic                 recall_en,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 node_rd_en,
  output logic [NODE_AW-1:0]   node_rd_addr,
  input  logic [DIST_W-1:0]    dist_in,
  output logic                 thr_rd_en,
  input  logic [DIST_W-1:0]    thr_in,
  output logic                 wr_en,
  output logic [1:0]           wr_op,
  output logic [NODE_AW-1:0]   wr_addr,
  output logic [NODE_AW-1:0]   wr_addr2,
  output logic [DIST_W-1:0]    s1_dist,
  output logic [NODE_AW:0]     node_count,
  output logic                 recall_valid,
  output logic [NODE_AW-1:0]   recall_idx,
  output logic                 done,
  output logic                 overflow,
  output logic                 busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_SCAN, S_DRAIN, S_THR_RD, S_DECIDE, S_WR_NEW,
    S_WR_S1, S_WR_S2, S_CONNECT, S_RECALL_OUT, S_DONE
  } state_t;

  localparam logic [1:0]         OP_NEW  = 2'b00;
  localparam logic [1:0]         OP_S1   = 2'b01;
  localparam logic [1:0]         OP_S2   = 2'b10;
  localparam logic [1:0]         OP_CONN = 2'b11;
  localparam logic [NODE_AW:0]   MAX_CNT = MAX_NODES[NODE_AW:0];
  localparam logic [NODE_AW:0]   CNT_ONE = (NODE_AW+1)'(1);
  localparam logic [NODE_AW-1:0] IDX_ONE = NODE_AW'(1);

  state_t              state_q, state_d;
  logic                rec_mode_q, rec_mode_d;
  logic [NODE_AW:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                rd_en_q, rd_en_d;
  logic [NODE_AW-1:0]  rd_addr_q, rd_addr_d;
  logic                thr_rd_q, thr_rd_d;
  logic                wr_en_q, wr_en_d;
  logic [1:0]          wr_op_q, wr_op_d;
  logic [NODE_AW-1:0]  wr_addr_q, wr_addr_d;
  logic [NODE_AW-1:0]  wr_addr2_q, wr_addr2_d;
  logic [DIST_W-1:0]   min1_q, min1_d, min2_q, min2_d;
  logic [NODE_AW-1:0]  s1_q, s1_d, s2_q, s2_d;
  logic                s2_vld_q, s2_vld_d;
  logic                rv_q, rv_d;
  logic [NODE_AW-1:0]  ridx_q, ridx_d;
  logic                done_q, done_d;
  logic                cmp_en;
  logic [NODE_AW-1:0]  cmp_idx;
  logic                accept;

  assign in_ready = (state_q == S_IDLE) && (learn_en || recall_en) && !reset;
  assign accept   = in_valid && in_ready;

  // Next-state, winner tracking and registered-output values
  always_comb begin
    state_d    = state_q;
    rec_mode_d = rec_mode_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    thr_rd_d   = 1'b0;
    wr_en_d    = 1'b0;
    wr_op_d    = wr_op_q;
    wr_addr_d  = wr_addr_q;
    wr_addr2_d = wr_addr2_q;
    min1_d     = min1_q;
    min2_d     = min2_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    s2_vld_d   = s2_vld_q;
    rv_d       = 1'b0;
    ridx_d     = ridx_q;
    done_d     = 1'b0;
    cmp_en     = 1'b0;
    cmp_idx    = '0;

    // dist_in belongs to the address read one cycle earlier
    if (state_q == S_SCAN && rd_addr_q != '0) begin
      cmp_en  = 1'b1;
      cmp_idx = rd_addr_q - IDX_ONE;
    end else if (state_q == S_DRAIN) begin
      cmp_en  = 1'b1;
      cmp_idx = rd_addr_q;
    end
    if (cmp_en) begin
      if (dist_in < min1_q) begin
        min2_d = min1_q;
        s2_d   = s1_q;
        min1_d = dist_in;
        s1_d   = cmp_idx;
      end else if (dist_in < min2_q) begin
        min2_d = dist_in;
        s2_d   = cmp_idx;
      end
      if (cmp_idx != '0) s2_vld_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rec_mode_d = recall_en;
          min1_d     = '1;
          min2_d     = '1;
          s1_d       = '0;
          s2_d       = '0;
          s2_vld_d   = 1'b0;
          if (cnt_q == '0) begin
            if (recall_en) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d   = S_WR_NEW;
              wr_en_d   = 1'b1;
              wr_op_d   = OP_NEW;
              wr_addr_d = cnt_q[NODE_AW-1:0];
            end
          end else begin
            state_d   = S_SCAN;
            rd_en_d   = 1'b1;
            rd_addr_d = '0;
          end
        end
      end
      S_SCAN: begin
        if ({1'b0, rd_addr_q} == cnt_q - CNT_ONE) begin
          state_d = S_DRAIN;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + IDX_ONE;
        end
      end
      S_DRAIN: begin
        rd_addr_d = '0;
        if (rec_mode_q) begin
          state_d = S_RECALL_OUT;
          rv_d    = 1'b1;
          ridx_d  = s1_d;
        end else begin
          state_d   = S_THR_RD;
          thr_rd_d  = 1'b1;
          wr_addr_d = s1_d;
        end
      end
      S_RECALL_OUT: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      S_THR_RD: state_d = S_DECIDE;
      S_DECIDE: begin
        wr_en_d = 1'b1;
        if (min1_q > thr_in && cnt_q < MAX_CNT) begin
          state_d   = S_WR_NEW;
          wr_op_d   = OP_NEW;
          wr_addr_d = cnt_q[NODE_AW-1:0];
        end else begin
          if (min1_q > thr_in) ovf_d = 1'b1;
          state_d   = S_WR_S1;
          wr_op_d   = OP_S1;
          wr_addr_d = s1_q;
        end
      end
      S_WR_NEW: begin
        if (cnt_q < MAX_CNT) cnt_d = cnt_q + CNT_ONE;
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      S_WR_S1: begin
        if (s2_vld_q) begin
          state_d   = S_WR_S2;
          wr_en_d   = 1'b1;
          wr_op_d   = OP_S2;
          wr_addr_d = s2_q;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_WR_S2: begin
        state_d    = S_CONNECT;
        wr_en_d    = 1'b1;
        wr_op_d    = OP_CONN;
        wr_addr_d  = s1_q;
        wr_addr2_d = s2_q;
      end
      S_CONNECT: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any operation immediately
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rec_mode_q <= 1'b0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      thr_rd_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_op_q    <= '0;
      wr_addr_q  <= '0;
      wr_addr2_q <= '0;
      min1_q     <= '0;
      min2_q     <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      s2_vld_q   <= 1'b0;
      rv_q       <= 1'b0;
      ridx_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rec_mode_q <= rec_mode_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      thr_rd_q   <= thr_rd_d;
      wr_en_q    <= wr_en_d;
      wr_op_q    <= wr_op_d;
      wr_addr_q  <= wr_addr_d;
      wr_addr2_q <= wr_addr2_d;
      min1_q     <= min1_d;
      min2_q     <= min2_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s2_vld_q   <= s2_vld_d;
      rv_q       <= rv_d;
      ridx_q     <= ridx_d;
      done_q     <= done_d;
    end
  end

  // A write strobe already on the bus is suppressed while reset is high
  assign wr_en        = wr_en_q && !reset;
  assign node_rd_en   = rd_en_q;
  assign node_rd_addr = rd_addr_q;
  assign thr_rd_en    = thr_rd_q;
  assign wr_op        = wr_op_q;
  assign wr_addr      = wr_addr_q;
  assign wr_addr2     = wr_addr2_q;
  assign s1_dist      = min1_q;
  assign node_count   = cnt_q;
  assign recall_valid = rv_q;
  assign recall_idx   = ridx_q;
  assign done         = done_q;
  assign overflow     = ovf_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_gam_memory_layer_seq.sv
// Bench for gam_memory_layer_seq: directed cases plus random operations,
// checked against an argmin-based reference of node count, writes and latency.
module tb_gam_memory_layer_seq;
  localparam int AW   = 4;
  localparam int MAXN = 10;
  localparam int DW   = 16;

  logic          clk = 1'b0;
  logic          reset, learn_en, recall_en, in_valid, in_ready;
  logic          node_rd_en, thr_rd_en, wr_en, recall_valid, done, overflow, busy;
  logic [AW-1:0] node_rd_addr, wr_addr, wr_addr2, recall_idx;
  logic [DW-1:0] dist_in, thr_in, s1_dist;
  logic [1:0]    wr_op;
  logic [AW:0]   node_count;

  gam_memory_layer_seq #(.NODE_AW(AW), .MAX_NODES(MAXN), .DIST_W(DW)) dut (
    .clk(clk), .reset(reset), .learn_en(learn_en), .recall_en(recall_en),
    .in_valid(in_valid), .in_ready(in_ready), .node_rd_en(node_rd_en),
    .node_rd_addr(node_rd_addr), .dist_in(dist_in), .thr_rd_en(thr_rd_en),
    .thr_in(thr_in), .wr_en(wr_en), .wr_op(wr_op), .wr_addr(wr_addr),
    .wr_addr2(wr_addr2), .s1_dist(s1_dist), .node_count(node_count),
    .recall_valid(recall_valid), .recall_idx(recall_idx), .done(done),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_err = 0;
  int            m_cnt = 0;
  bit            m_ovf = 1'b0;
  logic [DW-1:0] cur_d [0:15];
  logic [DW-1:0] cur_thr;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode: 0 learn, 1 recall, 2 both enables (recall wins). Starts and ends just after a negedge.
  task automatic run_op(input int mode);
    int n, s1, s2, lat, got_lat, rd_seq, rv_cnt, ridx;
    bit rec, prev_rd, prev_thr, got_busy, got_rdy;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] m1, m2;
    int e_op[$], e_a[$], e_a2[$], g_op[$], g_a[$], g_a2[$];
    n   = m_cnt;
    rec = (mode != 0);
    m1 = '1; s1 = 0;
    for (int i = 0; i < n; i++) if (cur_d[i] < m1) begin m1 = cur_d[i]; s1 = i; end
    m2 = '1; s2 = 0;
    for (int i = 0; i < n; i++) if (i != s1 && cur_d[i] < m2) begin m2 = cur_d[i]; s2 = i; end
    if (n == 0) begin
      if (rec) lat = 1;
      else begin e_op.push_back(0); e_a.push_back(0); e_a2.push_back(0); m_cnt++; lat = 2; end
    end else if (rec) begin
      lat = n + 3;
    end else if (m1 > cur_thr && m_cnt < MAXN) begin
      e_op.push_back(0); e_a.push_back(n); e_a2.push_back(0); m_cnt++; lat = n + 5;
    end else begin
      if (m1 > cur_thr) m_ovf = 1'b1;
      e_op.push_back(1); e_a.push_back(s1); e_a2.push_back(0);
      lat = n + 5;
      if (n >= 2) begin
        e_op.push_back(2); e_a.push_back(s2); e_a2.push_back(0);
        e_op.push_back(3); e_a.push_back(s1); e_a2.push_back(s2);
        lat = n + 7;
      end
    end

    learn_en  = (mode == 0 || mode == 2);
    recall_en = (mode != 0);
    in_valid  = 1'b1;
    #1 chk_val("in_ready_idle", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    learn_en  = 1'($urandom);
    recall_en = 1'($urandom);
    prev_rd = 0; prev_thr = 0; prev_addr = '0;
    got_lat = -1; rd_seq = 0; rv_cnt = 0; ridx = -1; got_busy = 0; got_rdy = 1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      dist_in = prev_rd ? cur_d[prev_addr] : DW'($urandom);
      thr_in  = prev_thr ? cur_thr : DW'($urandom);
      #1;
      if (node_rd_en) begin
        chk_val("rd_addr", node_rd_addr, rd_seq);
        rd_seq++;
      end
      if (thr_rd_en) chk_val("thr_rd_s1", wr_addr, s1);
      if (wr_en) begin
        g_op.push_back(wr_op); g_a.push_back(wr_addr);
        g_a2.push_back(wr_op == 2'b11 ? int'(wr_addr2) : 0);
      end
      if (recall_valid) begin rv_cnt++; ridx = recall_idx; end
      prev_rd = node_rd_en; prev_addr = node_rd_addr; prev_thr = thr_rd_en;
      if (done) begin got_lat = c; got_busy = busy; got_rdy = in_ready; break; end
    end
    if (got_lat < 0) chk_val("done_timeout", 0, 1);
    chk_val("latency", got_lat, lat);
    chk_val("reads", rd_seq, n);
    chk_val("busy_done", got_busy, 1);
    chk_val("in_ready_done", got_rdy, 0);
    chk_val("n_writes", g_op.size(), e_op.size());
    for (int i = 0; i < e_op.size() && i < g_op.size(); i++) begin
      chk_val("wr_op", g_op[i], e_op[i]);
      chk_val("wr_addr", g_a[i], e_a[i]);
      if (e_op[i] == 3) chk_val("wr_addr2", g_a2[i], e_a2[i]);
    end
    chk_val("recall_pulses", rv_cnt, (rec && n > 0) ? 1 : 0);
    if (rec && n > 0) chk_val("recall_idx", ridx, s1);
    if (n > 0) chk_val("s1_dist", s1_dist, m1);
    chk_val("node_count", node_count, m_cnt);
    chk_val("overflow", overflow, m_ovf);
    @(negedge clk);
    #1 chk_val("done_pulse", done, 0);
    chk_val("idle_busy", busy, 0);
  endtask

  task automatic rand_d(input int lo, input int hi);
    for (int i = 0; i < 16; i++) cur_d[i] = DW'($urandom_range(hi, lo));
  endtask

  initial begin
    reset = 1'b1; learn_en = 1'b1; recall_en = 1'b0; in_valid = 1'b1;
    dist_in = '0; thr_in = '0; cur_thr = '0;
    rand_d(0, 100);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk_val("rst_in_ready", in_ready, 0);
    chk_val("rst_busy", busy, 0);
    chk_val("rst_count", node_count, 0);
    chk_val("rst_ovf", overflow, 0);
    chk_val("rst_wr_en", wr_en, 0);
    chk_val("rst_rd_en", node_rd_en, 0);
    chk_val("rst_done", done, 0);
    chk_val("rst_s1_dist", s1_dist, 0);
    chk_val("rst_recall_idx", recall_idx, 0);
    reset = 1'b0; learn_en = 1'b0; in_valid = 1'b0;
    #1 chk_val("no_en_ready", in_ready, 0);

    run_op(1);                                    // recall with empty memory
    run_op(0);                                    // first node
    cur_d[0] = 100; cur_thr = 0; run_op(0);
    cur_d[1] = 100; run_op(0);
    cur_d[0] = 40; cur_d[1] = 10; cur_d[2] = 25; cur_thr = 30; run_op(0);
    cur_thr = 5; run_op(0);                       // new node 3
    for (int i = 0; i < 4; i++) cur_d[i] = 7;
    cur_thr = 100; run_op(0);                     // ties
    cur_d[0] = 9; cur_d[1] = 3; cur_d[2] = 20; cur_d[3] = 20; run_op(1);
    cur_d[0] = 50; cur_d[1] = 60; cur_d[2] = 4; cur_d[3] = 4; run_op(2);

    for (int k = 0; k < 30; k++) begin
      rand_d(0, 60);
      cur_thr = DW'($urandom_range(80, 0));
      run_op(($urandom_range(3, 0) == 0) ? int'($urandom_range(2, 1)) : 0);
    end
    while (m_cnt < MAXN) begin
      rand_d(1000, 2000); cur_thr = 0; run_op(0);
    end
    rand_d(100, 900); cur_thr = 0; run_op(0);     // full: overflow path
    for (int k = 0; k < 6; k++) begin
      rand_d(0, 40);
      cur_thr = DW'($urandom_range(50, 0));
      run_op(int'($urandom_range(2, 0)));
    end

    // reset during the scan
    learn_en = 1'b1; recall_en = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk_val("scan_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_val("abort_busy", busy, 0);
    chk_val("abort_count", node_count, 0);
    chk_val("abort_wr_en", wr_en, 0);
    chk_val("abort_rd_en", node_rd_en, 0);
    chk_val("abort_ovf", overflow, 0);
    chk_val("abort_in_ready", in_ready, 0);
    @(negedge clk);
    reset = 1'b0; m_cnt = 0; m_ovf = 1'b0;
    run_op(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
